multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPW, 6, opcode field width.
REQ-002 SHALL have parameter FNW, 6, funct field width.
REQ-003 SHALL have parameter ULACW, 3, ULAControl width; encodings use the low 3 bits, upper bits 0.
REQ-004 SHALL have parameter TIMEOUT, 16, max cycles waiting for mem_ready; 0 disables timeout.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports OP  in  OPW, and Funct  in  FNW, from the instruction register.
REQ-008 SHALL have port mem_ready  in  1  memory completion strobe.
REQ-009 SHALL have port mem_req  out  1  memory access request, held until mem_ready.
REQ-010 SHALL have outputs PCWrite, IRWrite, IorD, RegWrite, RegDst, MemtoReg, MemWrite, Branch, Link, ULASrcA (1 bit each).
REQ-011 SHALL have outputs ULASrcB  out  2  (00 reg, 01 const 4, 10 imm, 11 imm<<2) and PCSrc  out  2  (00 ULA, 01 ULAOut reg, 10 jump target, 11 rs).
REQ-012 SHALL have outputs ULAControl  out  ULACW; state  out  4; illegal  out  1; timeout  out  1.

Function
REQ-013 SHALL be a Moore FSM; only IRWrite/PCWrite in FETCH and MemtoReg-path writes in MEMRD are additionally gated by mem_ready.
REQ-014 SHALL encode state: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JAL 12, JR 13, HALT 15.
REQ-015 FETCH: mem_req=1, IorD=0; stay while mem_ready=0; on mem_ready: IRWrite=1, PCWrite=1, ULASrcA=0, ULASrcB=01, ULAControl=010, PCSrc=00, next DECODE.
REQ-016 DECODE: ULASrcA=0, ULASrcB=11, ULAControl=010; next by OP: 100011/101011 -> MEMADR, 000000 -> EXEC (or JR if Funct=001000), 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, 000011 -> JAL, other -> HALT.
REQ-017 MEMADR: ULASrcA=1, ULASrcB=10, ULAControl=010; next MEMRD for 100011, MEMWR for 101011.
REQ-018 MEMRD: mem_req=1, IorD=1; wait for mem_ready, then MEMWB. MEMWR: mem_req=1, IorD=1, MemWrite=1; on mem_ready -> FETCH.
REQ-019 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
REQ-020 EXEC: ULASrcA=1, ULASrcB=00; Funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111 -> ALUWB; any other Funct -> HALT.
REQ-021 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
REQ-022 BRANCH: ULASrcA=1, ULASrcB=00, ULAControl=110, Branch=1, PCSrc=01 -> FETCH.
REQ-023 ADDIEX: ULASrcA=1, ULASrcB=10, ULAControl=010 -> ADDIWB; ADDIWB: RegWrite=1, RegDst=0 -> FETCH.
REQ-024 JUMP: PCWrite=1, PCSrc=10 -> FETCH. JAL: PCWrite=1, PCSrc=10, RegWrite=1, Link=1 -> FETCH. JR: PCWrite=1, PCSrc=11 -> FETCH.
REQ-025 HALT: all strobes 0, illegal=1 (or timeout=1 per cause); stays until rst.
REQ-026 Wait counter SHALL clear on entering any mem_req state, increment each cycle mem_ready=0; reaching TIMEOUT -> HALT with timeout=1, illegal=0.
REQ-027 mem_ready asserted in a non-memory state SHALL be ignored; mem_ready in same cycle as wait-counter reaching TIMEOUT SHALL complete the access (no timeout).
REQ-028 All outputs not listed for a state SHALL be 0.

Reset
REQ-029 rst=1 SHALL asynchronously force state=FETCH, wait counter=0, illegal=0, timeout=0, mid-access included.
REQ-030 During reset all strobes SHALL be 0; mem_req SHALL be 0 while rst=1 and rise the first cycle after release.

Configuration
REQ-031 Macro MCU_JAL_JR_EN defined: JAL and JR states as specified.
REQ-032 Macro undefined: OP 000011 and R-type Funct 001000 route to HALT with illegal=1; Link output tied 0; states 12/13 unreachable.

Verification
REQ-033 lw, mem_ready 2-cycle delay in FETCH and MEMRD -> states 0,0,0,1,2,3,3,3,4,0; RegWrite=1 only in state 4.
REQ-034 add (OP 0, Funct 100000) -> 0,1,6,7,0; ULAControl=010 in state 6; RegDst=1 in 7.
REQ-035 beq -> 0,1,8,0; Branch=1, ULAControl=110, PCSrc=01 in state 8.
REQ-036 OP 111111 -> state 15, illegal=1 held 10 cycles; rst pulse -> state 0, illegal=0.
REQ-037 TIMEOUT=4, mem_ready held 0 in FETCH -> HALT after 4 cycles, timeout=1; repeat with mem_ready on 4th cycle -> DECODE.
REQ-038 jal with and without MCU_JAL_JR_EN -> states 0,1,12,0 with Link=1, versus 0,1,15 with illegal=1.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory-wait timeout; JAL/JR states enabled by MCU_JAL_JR_EN
module multicycle_control #(
    parameter int OPW     = 6,
    parameter int FNW     = 6,
    parameter int ULACW   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   OP,
    input  logic [FNW-1:0]   Funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             Branch,
    output logic             Link,
    output logic             ULASrcA,
    output logic [1:0]       ULASrcB,
    output logic [1:0]       PCSrc,
    output logic [ULACW-1:0] ULAControl,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             timeout
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_JAL    = 4'd12, S_JR     = 4'd13, S_HALT   = 4'd15
    } state_t;

    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);

    localparam logic [FNW-1:0] FN_ADD = FNW'(6'b100000);
    localparam logic [FNW-1:0] FN_SUB = FNW'(6'b100010);
    localparam logic [FNW-1:0] FN_AND = FNW'(6'b100100);
    localparam logic [FNW-1:0] FN_OR  = FNW'(6'b100101);
    localparam logic [FNW-1:0] FN_SLT = FNW'(6'b101010);
    localparam logic [FNW-1:0] FN_JR  = FNW'(6'b001000);

    // Wait counter counts 0..TIMEOUT-1; the access expires on the cycle it sits at TIMEOUT-1 without ready
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_illegal;
    logic           r_timeout;
    logic           w_expire;
    logic           w_fn_ok;
    logic [2:0]     w_alu;

    assign w_expire = (TIMEOUT != 0) && (r_cnt == CNT_LAST) && !mem_ready;
    assign w_fn_ok  = (Funct == FN_ADD) || (Funct == FN_SUB) || (Funct == FN_AND) ||
                      (Funct == FN_OR)  || (Funct == FN_SLT);

    // State, wait counter and sticky halt-cause flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= '0;
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) r_state <= S_DECODE;
                    else if (w_expire) begin
                        r_state   <= S_HALT;
                        r_timeout <= 1'b1;
                    end else r_cnt <= r_cnt + CW'(1);
                end
                S_DECODE: begin
                    if (OP == OP_LW || OP == OP_SW) r_state <= S_MEMADR;
                    else if (OP == OP_RTYPE) begin
                        if (Funct == FN_JR) begin
`ifdef MCU_JAL_JR_EN
                            r_state <= S_JR;
`else
                            r_state   <= S_HALT;
                            r_illegal <= 1'b1;
`endif
                        end else r_state <= S_EXEC;
                    end
                    else if (OP == OP_BEQ)  r_state <= S_BRANCH;
                    else if (OP == OP_ADDI) r_state <= S_ADDIEX;
                    else if (OP == OP_J)    r_state <= S_JUMP;
`ifdef MCU_JAL_JR_EN
                    else if (OP == OP_JAL)  r_state <= S_JAL;
`endif
                    else begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end
                end
                S_MEMADR: r_state <= (OP == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD, S_MEMWR: begin
                    if (mem_ready) r_state <= (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
                    else if (w_expire) begin
                        r_state   <= S_HALT;
                        r_timeout <= 1'b1;
                    end else r_cnt <= r_cnt + CW'(1);
                end
                S_EXEC: begin
                    if (w_fn_ok) r_state <= S_ALUWB;
                    else begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end
                end
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: r_state <= S_FETCH;
`ifdef MCU_JAL_JR_EN
                S_JAL, S_JR: r_state <= S_FETCH;
`endif
                S_HALT: r_state <= S_HALT;
                default: begin
                    r_state   <= S_HALT;
                    r_illegal <= 1'b1;
                end
            endcase
        end
    end

    // Moore output decode; only the FETCH fetch-complete strobes look at mem_ready
    always_comb begin
        mem_req  = 1'b0; PCWrite  = 1'b0; IRWrite = 1'b0; IorD    = 1'b0;
        RegWrite = 1'b0; RegDst   = 1'b0; MemtoReg = 1'b0; MemWrite = 1'b0;
        Branch   = 1'b0; Link     = 1'b0; ULASrcA = 1'b0; ULASrcB = 2'b00;
        PCSrc    = 2'b00; w_alu   = 3'b000;
        case (r_state)
            S_FETCH: begin
                mem_req = !rst;
                ULASrcB = 2'b01;
                w_alu   = 3'b010;
                if (mem_ready && !rst) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            S_DECODE: begin ULASrcB = 2'b11; w_alu = 3'b010; end
            S_MEMADR: begin ULASrcA = 1'b1; ULASrcB = 2'b10; w_alu = 3'b010; end
            S_MEMRD:  begin mem_req = 1'b1; IorD = 1'b1; end
            S_MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            S_MEMWR:  begin mem_req = 1'b1; IorD = 1'b1; MemWrite = 1'b1; end
            S_EXEC: begin
                ULASrcA = 1'b1;
                case (Funct)
                    FN_ADD:  w_alu = 3'b010;
                    FN_SUB:  w_alu = 3'b110;
                    FN_AND:  w_alu = 3'b000;
                    FN_OR:   w_alu = 3'b001;
                    FN_SLT:  w_alu = 3'b111;
                    default: w_alu = 3'b000;
                endcase
            end
            S_ALUWB:  begin RegWrite = 1'b1; RegDst = 1'b1; end
            S_BRANCH: begin ULASrcA = 1'b1; w_alu = 3'b110; Branch = 1'b1; PCSrc = 2'b01; end
            S_ADDIEX: begin ULASrcA = 1'b1; ULASrcB = 2'b10; w_alu = 3'b010; end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP:   begin PCWrite = 1'b1; PCSrc = 2'b10; end
`ifdef MCU_JAL_JR_EN
            S_JAL:    begin PCWrite = 1'b1; PCSrc = 2'b10; RegWrite = 1'b1; Link = 1'b1; end
            S_JR:     begin PCWrite = 1'b1; PCSrc = 2'b11; end
`endif
            default: ;
        endcase
    end

    assign ULAControl = ULACW'(w_alu);
    assign state      = r_state;
    assign illegal    = r_illegal;
    assign timeout    = r_timeout;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control against an instruction-level model
module tb_multicycle_control;
    localparam int TO = 4;
`ifdef MCU_JAL_JR_EN
    localparam bit JALJR = 1'b1;
`else
    localparam bit JALJR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] OP = '0;
    logic [5:0] Funct = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, PCWrite, IRWrite, IorD, RegWrite, RegDst, MemtoReg, MemWrite;
    logic       Branch, Link, ULASrcA, illegal, timeout;
    logic [1:0] ULASrcB, PCSrc;
    logic [2:0] ULAControl;
    logic [3:0] state;
    logic [19:0] obs;

    always #5 clk = ~clk;

    multicycle_control #(.OPW(6), .FNW(6), .ULACW(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .OP(OP), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .Branch(Branch), .Link(Link), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .PCSrc(PCSrc),
        .ULAControl(ULAControl), .state(state), .illegal(illegal), .timeout(timeout)
    );

    assign obs = {mem_req, PCWrite, IRWrite, IorD, RegWrite, RegDst, MemtoReg, MemWrite,
                  Branch, Link, ULASrcA, ULASrcB, PCSrc, ULAControl, illegal, timeout};

    typedef struct {
        int st;
        bit rdy;
        bit ill;
        bit to;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   halted = 1'b0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic bit rnd();
        return 1'($urandom % 2);
    endfunction

    // Control word each state must present, straight from the per-state output table
    function automatic logic [19:0] exp_out(int st, bit rdy, logic [5:0] fn, bit ill, bit to);
        logic mreq = 0, pcw = 0, irw = 0, iord = 0, rw = 0, rd = 0, m2r = 0, mw = 0, br = 0, lk = 0, sa = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] uc = 3'b000;
        case (st)
            0:  begin mreq = 1; sb = 2'b01; uc = 3'b010; if (rdy) begin irw = 1; pcw = 1; end end
            1:  begin sb = 2'b11; uc = 3'b010; end
            2:  begin sa = 1; sb = 2'b10; uc = 3'b010; end
            3:  begin mreq = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mreq = 1; iord = 1; mw = 1; end
            6:  begin
                    sa = 1;
                    if (fn == 6'b100000) uc = 3'b010;
                    else if (fn == 6'b100010) uc = 3'b110;
                    else if (fn == 6'b100100) uc = 3'b000;
                    else if (fn == 6'b100101) uc = 3'b001;
                    else if (fn == 6'b101010) uc = 3'b111;
                end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; uc = 3'b110; br = 1; ps = 2'b01; end
            9:  begin sa = 1; sb = 2'b10; uc = 3'b010; end
            10: rw = 1;
            11: begin pcw = 1; ps = 2'b10; end
            12: begin pcw = 1; ps = 2'b10; rw = 1; lk = 1; end
            13: begin pcw = 1; ps = 2'b11; end
            default: ;
        endcase
        return {mreq, pcw, irw, iord, rw, rd, m2r, mw, br, lk, sa, sb, ps, uc, ill, to};
    endfunction

    task automatic push(input int st, input bit rdy, input bit ill = 1'b0, input bit to = 1'b0);
        ent_t e;
        e.st = st; e.rdy = rdy; e.ill = ill; e.to = to;
        q.push_back(e);
    endtask

    task automatic halt(input bit ill, input bit to);
        repeat (10) push(15, rnd(), ill, to);
        halted = 1'b1;
    endtask

    // A memory access that sees w not-ready cycles; w >= TO means the memory never answers in time
    task automatic mem_access(input int st, input int w, output bit ok);
        if (w >= TO) begin
            repeat (TO) push(st, 1'b0);
            halt(1'b0, 1'b1);
            ok = 1'b0;
        end else begin
            repeat (w) push(st, 1'b0);
            push(st, 1'b1);
            ok = 1'b1;
        end
    endtask

    // Expected state trace of one instruction, from fetch to its last state
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int w1, input int w2);
        bit ok;
        halted = 1'b0;
        q.delete();
        mem_access(0, w1, ok);
        if (!ok) return;
        push(1, rnd());
        case (op)
            6'b100011: begin push(2, rnd()); mem_access(3, w2, ok); if (ok) push(4, rnd()); end
            6'b101011: begin push(2, rnd()); mem_access(5, w2, ok); end
            6'b000000: begin
                if (fn == 6'b001000) begin
                    if (JALJR) push(13, rnd());
                    else halt(1'b1, 1'b0);
                end else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
                    push(6, rnd()); push(7, rnd());
                end else begin
                    push(6, rnd()); halt(1'b1, 1'b0);
                end
            end
            6'b000100: push(8, rnd());
            6'b001000: begin push(9, rnd()); push(10, rnd()); end
            6'b000010: push(11, rnd());
            6'b000011: begin
                if (JALJR) push(12, rnd());
                else halt(1'b1, 1'b0);
            end
            default: halt(1'b1, 1'b0);
        endcase
    endtask

    task automatic run_seq(input int maxn);
        ent_t e;
        int   n = 0;
        while (q.size() > 0 && n < maxn) begin
            e = q.pop_front();
            mem_ready = e.rdy;
            @(negedge clk);
            chk($sformatf("c%0d_state", cyc), 32'(state), 32'(e.st));
            chk($sformatf("c%0d_outs", cyc), 32'(obs), 32'(exp_out(e.st, e.rdy, Funct, e.ill, e.to)));
            @(posedge clk); #1;
            cyc++;
            n++;
        end
        q.delete();
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'({mem_req, PCWrite, IRWrite, RegWrite, MemWrite, Branch, Link}), 32'd0);
        chk("rst_flags", 32'({illegal, timeout}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int w1, input int w2);
        OP = op;
        Funct = fn;
        add_instr(op, fn, w1, w2);
        run_seq(1000);
        if (halted) do_reset();
    endtask

    function automatic int rand_wait();
        return ($urandom % 8 == 0) ? TO : int'($urandom_range(0, TO - 1));
    endfunction

    initial begin
        logic [5:0] op, fn;
        @(negedge clk);
        chk("init_state", 32'(state), 32'd0);
        chk("init_mem_req", 32'(mem_req), 32'd0);
        chk("init_flags", 32'({illegal, timeout}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_instr(6'b100011, 6'b010101, 2, 2);                   // lw with slow memory
        do_instr(6'b000000, 6'b100000, 0, 0);                   // add
        do_instr(6'b000100, 6'b000000, 1, 0);                   // beq
        do_instr(6'b111111, 6'b000000, 0, 0);                   // illegal opcode
        do_instr(6'b000000, 6'b100000, TO, 0);                  // fetch timeout
        do_instr(6'b000000, 6'b100010, TO - 1, 0);              // ready on the last allowed cycle
        do_instr(6'b101011, 6'b000000, 0, TO);                  // store timeout
        do_instr(6'b000011, 6'b000000, 0, 0);                   // jal
        do_instr(6'b000000, 6'b001000, 0, 0);                   // jr
        do_instr(6'b000000, 6'b000111, 0, 0);                   // illegal funct

        // Reset asserted in the middle of a load's memory wait
        OP = 6'b100011; Funct = 6'b000000;
        add_instr(6'b100011, 6'b000000, 0, 3);
        run_seq(4);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 60; i++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 13))
                0:  op = 6'b100011;
                1:  op = 6'b101011;
                2:  begin op = 6'b000000; fn = 6'b100000; end
                3:  begin op = 6'b000000; fn = 6'b100010; end
                4:  begin op = 6'b000000; fn = 6'b100100; end
                5:  begin op = 6'b000000; fn = 6'b100101; end
                6:  begin op = 6'b000000; fn = 6'b101010; end
                7:  op = 6'b000100;
                8:  op = 6'b001000;
                9:  op = 6'b000010;
                10: op = 6'b000011;
                11: begin op = 6'b000000; fn = 6'b001000; end
                12: op = 6'b000000;
                default: op = 6'b111110;
            endcase
            do_instr(op, fn, rand_wait(), rand_wait());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
